alu_ext: RTL

ALU_EXT -- requirements
Module: alu_ext

---
 rtl/alu_ext.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_ext.sv
// Accumulator-style ALU with carry/zero/negative/overflow flags and a
// multi-cycle unsigned shift-add multiplier (one multiplier bit per cycle).
module alu_ext #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             ce_flags,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_r,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             cy,
  output logic             z,
  output logic             n,
  output logic             v
);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_RLC = 4'd7;
  localparam logic [3:0] OP_RRC = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [2*WIDTH-1:0] prod, prod_next;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic               ce_lat;
  logic               last_iter;
  logic [WIDTH:0]     sum, diff, mul_add;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_cy, alu_v, wr_res;

  // Single-cycle datapath; CMP shares the SBB subtractor with carry-in forced to 0.
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_r} + {{WIDTH{1'b0}}, cy};
    diff    = {1'b0, in_a} - {1'b0, in_r} - {{WIDTH{1'b0}}, (op == OP_SBB) & cy};
    alu_val = in_r;
    alu_cy  = 1'b0;
    alu_v   = 1'b0;
    wr_res  = 1'b1;
    case (op)
      OP_ADC: begin
        alu_val = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_r[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SBB, OP_CMP: begin
        alu_val = diff[WIDTH-1:0];
        alu_cy  = diff[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_r[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
        wr_res  = (op == OP_SBB);
      end
      OP_AND: alu_val = in_a & in_r;
      OP_OR:  alu_val = in_a | in_r;
      OP_XOR: alu_val = in_a ^ in_r;
      OP_NOT: alu_val = ~in_a;
      OP_RLC: begin
        alu_val = {in_a[WIDTH-2:0], cy};
        alu_cy  = in_a[WIDTH-1];
      end
      OP_RRC: begin
        alu_val = {cy, in_a[WIDTH-1:1]};
        alu_cy  = in_a[0];
      end
      default: alu_val = in_r;
    endcase
  end

  // Shift-add step: conditionally add multiplicand to the high half, shift right.
  always_comb begin
    mul_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod_next = {mul_add, prod[WIDTH-1:1]};
    last_iter = (cnt == CW'(WIDTH-1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && op == OP_MUL) state_next = RUN;
      RUN:     if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      done      <= 1'b0;
      cy        <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      cnt       <= '0;
      ce_lat    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        if (op == OP_MUL) begin
          prod   <= {{WIDTH{1'b0}}, in_r};
          mcand  <= in_a;
          cnt    <= '0;
          ce_lat <= ce_flags;
        end else begin
          done <= 1'b1;
          if (wr_res) begin
            result    <= alu_val;
            result_hi <= '0;
          end
          if (ce_flags) begin
            cy <= alu_cy;
            v  <= alu_v;
            z  <= (alu_val == '0);
            n  <= alu_val[WIDTH-1];
          end
        end
      end else if (state == RUN) begin
        prod <= prod_next;
        cnt  <= cnt + CW'(1);
        // Outputs only change once the full product is ready.
        if (last_iter) begin
          done      <= 1'b1;
          result    <= prod_next[WIDTH-1:0];
          result_hi <= prod_next[2*WIDTH-1:WIDTH];
          if (ce_lat) begin
            cy <= (prod_next[2*WIDTH-1:WIDTH] != '0);
            v  <= 1'b0;
            z  <= (prod_next == '0);
            n  <= prod_next[2*WIDTH-1];
          end
        end
      end
    end
  end

endmodule
